pe_array_feeder: RTL and testbench
==================================

# pe_array_feeder

Hardware sequencer that drives `PE_array_64` through a complete alignment, replacing the software stimulus loop. For each of 16 stripes it loads 64 gene-1 bases onto `i_B` and streams gene-2 bases onto `i_A`, starting at the accumulated stripe start position. It collects per-stripe end position and max score. After the last stripe it captures the trace-back direction stream into an external trace buffer.

## Interface
- `SEQ_LEN`, 1024: gene-2 length in bases; address width 10.
- `NUM_STRIPES`, 16: stripes per alignment (gene-1 length / 64).
- `TIMEOUT`, 2000: maximum cycles per stripe before abort.
- `TRACE_MAX`, 2048: trace buffer depth.

- `i_clk` input 1: clock.
- `i_rst` input 1: synchronous, active-high reset.
- `i_go` input 1: one-cycle pulse that starts an alignment; ignored while `o_busy`.
- `o_a_addr` output 10: gene-2 SRAM address; read data returns 1 cycle later.
- `i_a_data` input 2: gene-2 base.
- `o_b_addr` output 4: gene-1 SRAM row (one stripe of 64 bases); 1-cycle read latency.
- `i_b_data` input 128: 64 bases; base n at bits [2n+1:2n].
- `o_start` output 1: to PE `i_start`.
- `o_A` output 2: to PE `i_A`.
- `o_B` output 128: to PE `i_B`; held stable for the whole stripe.
- `i_stripe_end` input 1: from PE `o_stripe_end`.
- `i_start_position` input 10: from PE `o_start_position`.
- `i_end_position` input 10: from PE `o_end_position`.
- `i_max_score_stripe` input 14: from PE `o_max_score_stripe`.
- `i_trace_dir` input 2: from PE `o_trace_dir`.
- `o_stripe_valid` output 1: one-cycle pulse when stripe results are valid.
- `o_stripe_idx` output 4: index of the current or reported stripe.
- `o_end_pos_abs` output 11: `i_end_position + start_pos_reg`, zero-extended 11-bit add.
- `o_max_score` output 14: captured `i_max_score_stripe`.
- `o_tb_we` output 1: trace buffer write enable.
- `o_tb_addr` output 11: trace buffer write address.
- `o_tb_data` output 2: trace buffer write data.
- `o_tb_len` output 12: number of trace entries written.
- `o_busy` output 1: high from the cycle after an accepted `i_go` until DONE.
- `o_done` output 1: one-cycle pulse at the end of the alignment.
- `o_error` output 1: sticky timeout flag; cleared by reset or by an accepted `i_go`.

## Operation
- States: IDLE, LOAD_B, SETUP, STREAM, DRAIN, TRACE_WAIT, TRACE, DONE.
- **IDLE:** on `i_go`:
  - clear `start_pos_reg` (10-bit), the stripe counter k, `o_tb_len` and `o_error`;
  - go to LOAD_B.
- **LOAD_B:**
  - `o_b_addr`=k, `o_start`=0;
  - clear the per-stripe cycle counter `j` (counts stripe cycles and drives the timeout);
  - go to SETUP.
- **SETUP:**
  - register `i_b_data` into `o_B`;
  - `o_a_addr`=`start_pos_reg`, and set the stream pointer `p`=`start_pos_reg`;
  - `o_start`=0 (one idle cycle before streaming);
  - go to STREAM.
- **STREAM:**
  - each cycle `o_start`=1, `o_A`=`i_a_data`; `p` increments and `o_a_addr`=`p`+1;
  - when `p`==SEQ_LEN-1 has been presented, go to DRAIN.
- **DRAIN:** `o_start`=0, `o_A`=0; wait for `i_stripe_end`.
- **Stripe end** (`i_stripe_end` sampled high in STREAM or DRAIN):
  - capture `o_end_pos_abs` and `o_max_score`, and pulse `o_stripe_valid` the next cycle;
  - update `start_pos_reg` ← min(`start_pos_reg` + `i_start_position`, SEQ_LEN-1), computed as an 11-bit sum and clamped;
  - if k < NUM_STRIPES-1: increment k and go to LOAD_B;
  - otherwise go to TRACE_WAIT.
- **Timeout:** `j` increments every SETUP/STREAM/DRAIN cycle. If `j` reaches TIMEOUT without `i_stripe_end`:
  - set `o_error`;
  - go to DONE without tracing.
- **TRACE_WAIT:** wait for `i_stripe_end`==0, then go to TRACE.
- **TRACE:**
  - each cycle `o_tb_we`=1, `o_tb_data`=`i_trace_dir`, `o_tb_addr`=`o_tb_len`; `o_tb_len` increments;
  - the entry written in the cycle where `i_stripe_end`=1 is the last one;
  - also stop once `o_tb_len` reaches TRACE_MAX;
  - then go to DONE.
- **DONE:** pulse `o_done`, go to IDLE.
- **Priority within a cycle:** `i_rst` > stripe end > timeout > stream advance.

## Timing
- All outputs are registered.
- Reset values:
  - all outputs 0 and `o_B`=0;
  - state IDLE, `start_pos_reg`=0, k=0.
- `i_rst` mid-operation aborts immediately. In-flight results are discarded and `o_done` is not pulsed.
- `i_go` to the first `o_start`=1 takes 3 cycles: IDLE→LOAD_B→SETUP→STREAM.
- Stripe end to the next stripe's first `o_start`=1 takes 3 cycles.
- `o_start` falls in the cycle after `i_stripe_end` is sampled, even mid-stream.
- `o_B` changes only on the SETUP→STREAM edge.
- `o_stripe_valid` fires 1 cycle after `i_stripe_end` is sampled.
- `o_done` fires 1 cycle after the last trace write.

## Test plan
- **Reset mid-STREAM** (stripe 3): all outputs return to 0 next cycle and `o_done` never pulses; a new `i_go` restarts from stripe 0 at `o_a_addr`=0.
- **Single stripe:** PE model asserts `i_stripe_end` with `i_start_position`=37, `i_end_position`=500, max=120. Required: `o_end_pos_abs`=500, `o_max_score`=120, and stripe 1's first `o_a_addr`=37 with `o_B` = row 1.
- **Accumulation:** stripe 5 `start_pos_reg`=400 and `i_end_position`=1000 gives `o_end_pos_abs`=1400 (11-bit, no wrap).
- **Clamp:** `start_pos_reg`=1000 plus `i_start_position`=50 gives next start 1023; exactly one base is streamed, then DRAIN.
- **Timeout:** PE model never asserts `i_stripe_end` in stripe 0. `o_error`=1 after 2000 cycles, `o_done` pulses, and `o_tb_we` never rises.
- **Trace:** after stripe 15, `i_stripe_end` drops, then 300 directions are driven with `i_stripe_end` high on the 300th. Required: 300 writes at addresses 0..299 matching the data, `o_tb_len`=300, and `o_done` one cycle later.

Source files
------------

// File: rtl/pe_array_feeder.sv
// pe_array_feeder: sequences PE_array_64 through one alignment.
// Each of the stripes loads a gene-1 row onto o_B and streams gene-2 bases onto
// o_A from the accumulated start position, collects the stripe result, and after
// the last stripe copies the PE trace-back direction stream into a trace buffer.
module pe_array_feeder #(
    parameter  int unsigned SEQ_LEN     = 1024,
    parameter  int unsigned NUM_STRIPES = 16,
    parameter  int unsigned TIMEOUT     = 2000,
    parameter  int unsigned TRACE_MAX   = 2048,
    localparam int unsigned AW          = $clog2(SEQ_LEN),
    localparam int unsigned KW          = $clog2(NUM_STRIPES),
    localparam int unsigned TAW         = $clog2(TRACE_MAX),
    localparam int unsigned TLW         = $clog2(TRACE_MAX + 1)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_go,
    output logic [AW-1:0]  o_a_addr,
    input  logic [1:0]     i_a_data,
    output logic [KW-1:0]  o_b_addr,
    input  logic [127:0]   i_b_data,
    output logic           o_start,
    output logic [1:0]     o_A,
    output logic [127:0]   o_B,
    input  logic           i_stripe_end,
    input  logic [AW-1:0]  i_start_position,
    input  logic [AW-1:0]  i_end_position,
    input  logic [13:0]    i_max_score_stripe,
    input  logic [1:0]     i_trace_dir,
    output logic           o_stripe_valid,
    output logic [KW-1:0]  o_stripe_idx,
    output logic [AW:0]    o_end_pos_abs,
    output logic [13:0]    o_max_score,
    output logic           o_tb_we,
    output logic [TAW-1:0] o_tb_addr,
    output logic [1:0]     o_tb_data,
    output logic [TLW-1:0] o_tb_len,
    output logic           o_busy,
    output logic           o_done,
    output logic           o_error
);

    localparam int unsigned JW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_B, S_SETUP, S_STREAM, S_DRAIN, S_TRACE_WAIT, S_TRACE, S_DONE
    } state_t;

    state_t state, state_n;

    // Internal sequencing registers.
    logic [KW-1:0] k,         k_n;
    logic [JW-1:0] j,         j_n;
    logic [AW-1:0] p,         p_n;
    logic [AW-1:0] start_pos, start_pos_n;

    // Next values of the registered outputs.
    logic [AW-1:0]  a_addr_n;
    logic [KW-1:0]  b_addr_n;
    logic           start_n;
    logic [1:0]     a_n;
    logic [127:0]   b_n;
    logic           stripe_valid_n;
    logic [KW-1:0]  stripe_idx_n;
    logic [AW:0]    end_pos_abs_n;
    logic [13:0]    max_score_n;
    logic           tb_we_n;
    logic [TAW-1:0] tb_addr_n;
    logic [1:0]     tb_data_n;
    logic [TLW-1:0] tb_len_n;
    logic           busy_n;
    logic           done_n;
    logic           error_n;

    // Shared decode of the per-cycle events.
    logic          in_stripe;
    logic          stripe_end_hit;
    logic          timeout_hit;
    logic          last_stripe;
    logic          last_base;
    logic          trace_last;
    logic [AW:0]   start_sum;
    logic [AW-1:0] start_upd;
    logic [AW-1:0] a_addr_inc;

    // Event decode: stripe end outranks timeout, which outranks stream advance.
    always_comb begin
        in_stripe      = (state == S_SETUP) || (state == S_STREAM) || (state == S_DRAIN);
        stripe_end_hit = ((state == S_STREAM) || (state == S_DRAIN)) && i_stripe_end;
        timeout_hit    = in_stripe && !stripe_end_hit && (j == JW'(TIMEOUT - 1));
        last_stripe    = (k == KW'(NUM_STRIPES - 1));
        last_base      = (p == AW'(SEQ_LEN - 1));
        trace_last     = i_stripe_end || (o_tb_len == TLW'(TRACE_MAX - 1));
        start_sum      = (AW + 1)'(start_pos) + (AW + 1)'(i_start_position);
        start_upd      = (start_sum > (AW + 1)'(SEQ_LEN - 1)) ? AW'(SEQ_LEN - 1)
                                                               : start_sum[AW-1:0];
        // Address runs two ahead of o_A; it parks on the last base instead of wrapping.
        a_addr_inc     = (o_a_addr == AW'(SEQ_LEN - 1)) ? o_a_addr : o_a_addr + AW'(1);
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:       if (i_go) state_n = S_LOAD_B;
            S_LOAD_B:     state_n = S_SETUP;
            S_SETUP:      state_n = timeout_hit ? S_DONE : S_STREAM;
            S_STREAM: begin
                if (stripe_end_hit)   state_n = last_stripe ? S_TRACE_WAIT : S_LOAD_B;
                else if (timeout_hit) state_n = S_DONE;
                else if (last_base)   state_n = S_DRAIN;
            end
            S_DRAIN: begin
                if (stripe_end_hit)   state_n = last_stripe ? S_TRACE_WAIT : S_LOAD_B;
                else if (timeout_hit) state_n = S_DONE;
            end
            S_TRACE_WAIT: if (!i_stripe_end) state_n = S_TRACE;
            S_TRACE:      if (trace_last) state_n = S_DONE;
            S_DONE:       state_n = S_IDLE;
            default:      state_n = S_IDLE;
        endcase
    end

    // Output and datapath next values; pulses default low, everything else holds.
    always_comb begin
        k_n            = k;
        j_n            = j;
        p_n            = p;
        start_pos_n    = start_pos;
        a_addr_n       = o_a_addr;
        b_addr_n       = o_b_addr;
        start_n        = 1'b0;
        a_n            = 2'd0;
        b_n            = o_B;
        stripe_valid_n = 1'b0;
        stripe_idx_n   = o_stripe_idx;
        end_pos_abs_n  = o_end_pos_abs;
        max_score_n    = o_max_score;
        tb_we_n        = 1'b0;
        tb_addr_n      = o_tb_addr;
        tb_data_n      = o_tb_data;
        tb_len_n       = o_tb_len;
        busy_n         = o_busy;
        done_n         = 1'b0;
        error_n        = o_error;

        case (state)
            S_IDLE: begin
                if (i_go) begin
                    k_n          = '0;
                    start_pos_n  = '0;
                    tb_len_n     = '0;
                    error_n      = 1'b0;
                    busy_n       = 1'b1;
                    b_addr_n     = '0;
                    a_addr_n     = '0;
                    stripe_idx_n = '0;
                end
            end
            S_LOAD_B: begin
                j_n          = '0;
                a_addr_n     = a_addr_inc;
                stripe_idx_n = k;
            end
            S_SETUP: begin
                j_n = j + JW'(1);
                if (timeout_hit) begin
                    error_n = 1'b1;
                end else begin
                    b_n      = i_b_data;
                    p_n      = start_pos;
                    start_n  = 1'b1;
                    a_n      = i_a_data;
                    a_addr_n = a_addr_inc;
                end
            end
            S_STREAM, S_DRAIN: begin
                j_n = j + JW'(1);
                if (stripe_end_hit) begin
                    stripe_valid_n = 1'b1;
                    stripe_idx_n   = k;
                    end_pos_abs_n  = (AW + 1)'(i_end_position) + (AW + 1)'(start_pos);
                    max_score_n    = i_max_score_stripe;
                    start_pos_n    = start_upd;
                    if (!last_stripe) begin
                        k_n      = k + KW'(1);
                        b_addr_n = k + KW'(1);
                        a_addr_n = start_upd;
                    end
                end else if (timeout_hit) begin
                    error_n = 1'b1;
                end else if ((state == S_STREAM) && !last_base) begin
                    start_n  = 1'b1;
                    a_n      = i_a_data;
                    p_n      = p + AW'(1);
                    a_addr_n = a_addr_inc;
                end
            end
            S_TRACE: begin
                tb_we_n   = 1'b1;
                tb_data_n = i_trace_dir;
                tb_addr_n = o_tb_len[TAW-1:0];
                tb_len_n  = o_tb_len + TLW'(1);
            end
            S_DONE: begin
                done_n = 1'b1;
                busy_n = 1'b0;
            end
            default: ;
        endcase
    end

    // Registered outputs and sequencing state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            k              <= '0;
            j              <= '0;
            p              <= '0;
            start_pos      <= '0;
            o_a_addr       <= '0;
            o_b_addr       <= '0;
            o_start        <= 1'b0;
            o_A            <= 2'd0;
            o_B            <= '0;
            o_stripe_valid <= 1'b0;
            o_stripe_idx   <= '0;
            o_end_pos_abs  <= '0;
            o_max_score    <= '0;
            o_tb_we        <= 1'b0;
            o_tb_addr      <= '0;
            o_tb_data      <= 2'd0;
            o_tb_len       <= '0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_error        <= 1'b0;
        end else begin
            k              <= k_n;
            j              <= j_n;
            p              <= p_n;
            start_pos      <= start_pos_n;
            o_a_addr       <= a_addr_n;
            o_b_addr       <= b_addr_n;
            o_start        <= start_n;
            o_A            <= a_n;
            o_B            <= b_n;
            o_stripe_valid <= stripe_valid_n;
            o_stripe_idx   <= stripe_idx_n;
            o_end_pos_abs  <= end_pos_abs_n;
            o_max_score    <= max_score_n;
            o_tb_we        <= tb_we_n;
            o_tb_addr      <= tb_addr_n;
            o_tb_data      <= tb_data_n;
            o_tb_len       <= tb_len_n;
            o_busy         <= busy_n;
            o_done         <= done_n;
            o_error        <= error_n;
        end
    end

endmodule

// File: tb/tb_pe_array_feeder.sv
// Bench for pe_array_feeder: SRAM models, a scripted PE model and a reference
// of stripe start positions, streamed bases and trace contents.
module tb_pe_array_feeder;

    logic         clk = 1'b0;
    logic         rst;
    logic         go;
    logic [9:0]   a_addr;
    logic [1:0]   a_data;
    logic [3:0]   b_addr;
    logic [127:0] b_data;
    logic         start;
    logic [1:0]   a_out;
    logic [127:0] b_out;
    logic         stripe_end;
    logic [9:0]   start_position;
    logic [9:0]   end_position;
    logic [13:0]  max_score_stripe;
    logic [1:0]   trace_dir;
    logic         stripe_valid;
    logic [3:0]   stripe_idx;
    logic [10:0]  end_pos_abs;
    logic [13:0]  max_score;
    logic         tb_we;
    logic [10:0]  tb_addr;
    logic [1:0]   tb_data;
    logic [11:0]  tb_len;
    logic         busy;
    logic         done;
    logic         error;

    int tests = 0;
    int fails = 0;

    logic [1:0]   g2 [1024];
    logic [127:0] g1 [16];

    int           cur_start;
    logic [127:0] prev_b;

    int           n_we   = 0;
    int           n_done = 0;
    logic [10:0]  wr_addr_q [$];
    logic [1:0]   wr_data_q [$];

    logic [75:0]  all_out;
    assign all_out = {a_addr, b_addr, start, a_out, stripe_valid, stripe_idx, end_pos_abs,
                      max_score, tb_we, tb_addr, tb_data, tb_len, busy, done, error};

    always #5 clk = ~clk;

    pe_array_feeder dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_go              (go),
        .o_a_addr          (a_addr),
        .i_a_data          (a_data),
        .o_b_addr          (b_addr),
        .i_b_data          (b_data),
        .o_start           (start),
        .o_A               (a_out),
        .o_B               (b_out),
        .i_stripe_end      (stripe_end),
        .i_start_position  (start_position),
        .i_end_position    (end_position),
        .i_max_score_stripe(max_score_stripe),
        .i_trace_dir       (trace_dir),
        .o_stripe_valid    (stripe_valid),
        .o_stripe_idx      (stripe_idx),
        .o_end_pos_abs     (end_pos_abs),
        .o_max_score       (max_score),
        .o_tb_we           (tb_we),
        .o_tb_addr         (tb_addr),
        .o_tb_data         (tb_data),
        .o_tb_len          (tb_len),
        .o_busy            (busy),
        .o_done            (done),
        .o_error           (error)
    );

    // Gene SRAMs with one cycle of read latency.
    always @(posedge clk) begin
        a_data <= g2[a_addr];
        b_data <= g1[b_addr];
    end

    // Trace-buffer and done monitor.
    always @(negedge clk) begin
        if (tb_we) begin
            n_we++;
            wr_addr_q.push_back(tb_addr);
            wr_data_q.push_back(tb_data);
        end
        if (done) n_done++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse go from IDLE and check the LOAD_B cycle.
    task automatic start_go();
        go = 1'b1;
        step();
        go = 1'b0;
        cur_start = 0;
        tests++;
        if (busy !== 1'b1 || a_addr !== 10'd0 || b_addr !== 4'd0 || error !== 1'b0 || start !== 1'b0) begin
            fails++;
            $display("FAIL go_load_b: busy=%b a_addr=%0d b_addr=%0d error=%b start=%b required 1/0/0/0/0",
                     busy, a_addr, b_addr, error, start);
        end
    endtask

    // One stripe as the PE sees it; entered at the LOAD_B cycle. The PE raises
    // stripe_end on cycle n_cyc-1 counted from the first streamed base.
    task automatic run_stripe(input int k, input int n_cyc, input logic [9:0] sp,
                              input logic [9:0] ep, input logic [13:0] mx, input bit go_poke);
        int avail;
        int bad;
        logic [10:0] exp_abs;
        avail = 1024 - cur_start;
        step();
        tests++;
        if (start !== 1'b0 || b_out !== prev_b) begin
            fails++;
            $display("FAIL setup_stripe%0d: start=%b b_changed=%b required start=0 and o_B held",
                     k, start, b_out !== prev_b);
        end
        step();
        bad = 0;
        for (int c = 0; c < n_cyc; c++) begin
            if (c > 0) step();
            if (c < avail) begin
                if (start !== 1'b1 || a_out !== g2[cur_start + c] || b_out !== g1[k]) begin
                    if (bad == 0)
                        $display("FAIL stream_stripe%0d: cycle %0d start=%b A=%0d row_ok=%b required start=1 A=%0d",
                                 k, c, start, a_out, b_out === g1[k], g2[cur_start + c]);
                    bad++;
                end
            end else begin
                if (start !== 1'b0 || a_out !== 2'd0) begin
                    if (bad == 0)
                        $display("FAIL drain_stripe%0d: cycle %0d start=%b A=%0d required 0/0", k, c, start, a_out);
                    bad++;
                end
            end
            go = (go_poke && c == 0);
            if (c == n_cyc - 1) begin
                stripe_end       = 1'b1;
                start_position   = sp;
                end_position     = ep;
                max_score_stripe = mx;
            end
        end
        tests++;
        if (bad != 0) fails++;
        step();
        stripe_end = 1'b0;
        go = 1'b0;
        exp_abs = 11'(cur_start) + 11'(ep);
        tests++;
        if (stripe_valid !== 1'b1 || stripe_idx !== 4'(k) || end_pos_abs !== exp_abs ||
            max_score !== mx || start !== 1'b0) begin
            fails++;
            $display("FAIL result_stripe%0d: valid=%b idx=%0d end_abs=%0d max=%0d start=%b required 1/%0d/%0d/%0d/0",
                     k, stripe_valid, stripe_idx, end_pos_abs, max_score, start, k, exp_abs, mx);
        end
        prev_b = g1[k];
        cur_start = (cur_start + int'(sp) > 1023) ? 1023 : cur_start + int'(sp);
        if (k < 15) begin
            tests++;
            if (a_addr !== 10'(cur_start) || b_addr !== 4'(k + 1) || busy !== 1'b1) begin
                fails++;
                $display("FAIL next_stripe%0d: a_addr=%0d b_addr=%0d busy=%b required %0d/%0d/1",
                         k + 1, a_addr, b_addr, busy, cur_start, k + 1);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        tests++;
        if (all_out !== '0 || b_out !== '0) begin
            fails++;
            $display("FAIL reset_values: outputs=%h o_B=%h required all zero", all_out, b_out);
        end
        rst = 1'b0;
        prev_b = '0;
        step();
    endtask

    // Full alignment: first stripe values, accumulation, clamp, then the trace.
    task automatic test_alignment();
        int sp_tab [16];
        int ep_tab [16];
        int mx_tab [16];
        int n_cyc;
        int done_before;
        logic [1:0] dirs [300];
        int bad;
        sp_tab = '{37, 90, 91, 92, 90, 300, 300, 50, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int s = 0; s < 16; s++) begin
            if (s >= 8) sp_tab[s] = int'($urandom_range(0, 1023));
            ep_tab[s] = int'($urandom_range(0, 1023));
            mx_tab[s] = int'($urandom_range(0, 16383));
        end
        ep_tab[0] = 500;
        mx_tab[0] = 120;
        ep_tab[5] = 1000;
        done_before = n_done;
        start_go();
        for (int s = 0; s < 16; s++) begin
            if (s == 0) n_cyc = 600;
            else if (s == 8) n_cyc = 4;
            else n_cyc = int'($urandom_range(1, 1027 - cur_start));
            run_stripe(s, n_cyc, 10'(sp_tab[s]), 10'(ep_tab[s]), 14'(mx_tab[s]), s == 2);
        end
        // Now in TRACE_WAIT with stripe_end low.
        wr_addr_q.delete();
        wr_data_q.delete();
        for (int i = 0; i < 300; i++) dirs[i] = 2'($urandom_range(0, 3));
        step();
        for (int i = 0; i < 300; i++) begin
            if (i > 0) step();
            trace_dir  = dirs[i];
            stripe_end = (i == 299);
        end
        step();
        stripe_end = 1'b0;
        tests++;
        if (tb_we !== 1'b1 || tb_len !== 12'd300 || done !== 1'b0) begin
            fails++;
            $display("FAIL trace_last_write: we=%b len=%0d done=%b required 1/300/0", tb_we, tb_len, done);
        end
        step();
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || tb_we !== 1'b0 || tb_len !== 12'd300) begin
            fails++;
            $display("FAIL trace_done: done=%b busy=%b we=%b len=%0d required 1/0/0/300", done, busy, tb_we, tb_len);
        end
        step();
        bad = 0;
        tests++;
        if (wr_addr_q.size() != 300) begin
            fails++;
            $display("FAIL trace_count: writes=%0d required 300", wr_addr_q.size());
        end else begin
            for (int i = 0; i < 300; i++) begin
                if (wr_addr_q[i] !== 11'(i) || wr_data_q[i] !== dirs[i]) begin
                    if (bad == 0)
                        $display("FAIL trace_entry: index %0d addr=%0d data=%0d required addr=%0d data=%0d",
                                 i, wr_addr_q[i], wr_data_q[i], i, dirs[i]);
                    bad++;
                end
            end
            if (bad != 0) fails++;
        end
        tests++;
        if (n_done - done_before != 1) begin
            fails++;
            $display("FAIL done_count: pulses=%0d required 1", n_done - done_before);
        end
    endtask

    // PE never ends stripe 0: error after 2000 counted cycles, done, no trace.
    task automatic test_timeout();
        int we_before;
        int err_at;
        int done_at;
        we_before = n_we;
        err_at = -1;
        done_at = -1;
        stripe_end = 1'b0;
        start_go();
        for (int n = 2; n < 2106; n++) begin
            step();
            if (error === 1'b1 && err_at < 0) err_at = n;
            if (done === 1'b1) begin
                done_at = n;
                break;
            end
        end
        tests++;
        if (err_at != 2002) begin
            fails++;
            $display("FAIL timeout_error_cycle: got %0d required 2002", err_at);
        end
        tests++;
        if (done_at != 2003) begin
            fails++;
            $display("FAIL timeout_done_cycle: got %0d required 2003", done_at);
        end
        step();
        tests++;
        if (error !== 1'b1 || busy !== 1'b0 || n_we != we_before) begin
            fails++;
            $display("FAIL timeout_after: error=%b busy=%b trace_writes=%0d required 1/0/0",
                     error, busy, n_we - we_before);
        end
        prev_b = g1[0];
    endtask

    // Reset during stripe 3, then restart from stripe 0.
    task automatic test_reset_mid_stream();
        int done_before;
        start_go();
        for (int s = 0; s < 3; s++)
            run_stripe(s, int'($urandom_range(1, 50)), 10'($urandom_range(0, 300)),
                       10'($urandom_range(0, 1023)), 14'($urandom_range(0, 16383)), 1'b0);
        step();
        step();
        step();
        step();
        done_before = n_done;
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++;
        if (all_out !== '0 || b_out !== '0) begin
            fails++;
            $display("FAIL reset_mid_stream: outputs=%h o_B=%h required all zero", all_out, b_out);
        end
        for (int i = 0; i < 5; i++) step();
        tests++;
        if (n_done != done_before || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_no_done: done_pulses=%0d busy=%b required 0/0", n_done - done_before, busy);
        end
        prev_b = '0;
        start_go();
        run_stripe(0, 20, 10'd5, 10'd77, 14'd999, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1;
        go = 1'b0;
        stripe_end = 1'b0;
        start_position = '0;
        end_position = '0;
        max_score_stripe = '0;
        trace_dir = '0;
        cur_start = 0;
        prev_b = '0;
        for (int i = 0; i < 1024; i++) g2[i] = 2'($urandom_range(0, 3));
        for (int i = 0; i < 16; i++) g1[i] = {$urandom, $urandom, $urandom, $urandom};
        test_reset();
        test_alignment();
        test_timeout();
        test_reset_mid_stream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
